// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
// FSM state encoding, funct3 codes and the op legality check.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      RESP,
      FAULT
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // An op is legal when it is exactly one of load/store,
   // its width code exists for that op, and it is aligned.
   function automatic logic op_legal(
      input logic       ld,
      input logic       st,
      input logic [2:0] f3,
      input logic [1:0] lo
   );
      logic ok;
      ok = 1'b0;
      if (ld ^ st) begin
         case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~lo[0];
            F3_LW:   ok = (lo == 2'b00);
            F3_LBU:  ok = ld;
            F3_LHU:  ok = ld & ~lo[0];
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and load extension.
// Purely combinational; lane is the low two address bits.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Store byte enables and replicated write data by width.
   always_comb begin
      wstrb = 4'b1111;
      wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            wstrb = 4'b0001 << lane;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            wstrb = 4'b0011 << lane;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   // Select the addressed lane and sign/zero extend it.
   always_comb begin
      shifted   = rdata >> {lane, 3'b000};
      load_data = shifted;
      case (funct3)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  load_data = {24'd0, shifted[7:0]};
         F3_LHU:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data memory access unit.
// Captures one op, drives a req/gnt bus, returns load results.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t  state, state_d;
   logic        is_load_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] sdata_q;
   logic [4:0]  rd_q;
   logic [31:0] rdata_q;
   logic [CW-1:0] cnt;

   logic        accept;
   logic [3:0]  al_strb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   assign accept = in_valid & in_ready & (is_load | is_store);

   lsu_align u_align (
      .funct3     (f3_q),
      .lane       (addr_q[1:0]),
      .store_data (sdata_q),
      .rdata      (rdata_q),
      .wstrb      (al_strb),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (op_legal(is_load, is_store, funct3, addr[1:0]))
                  state_d = REQ;
               else
                  state_d = FAULT;
            end
         end
         REQ: begin
            if (mem_gnt) state_d = is_load_q ? WAIT : IDLE;
         end
         WAIT: begin
            if (mem_rvalid)
               state_d = RESP;
            else if (cnt == CW'(TIMEOUT - 1))
               state_d = FAULT;
         end
         RESP:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the op on accept and the read data on rvalid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         is_load_q <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         sdata_q   <= '0;
         rd_q      <= '0;
         rdata_q   <= '0;
      end else begin
         if (accept) begin
            is_load_q <= is_load;
            f3_q      <= funct3;
            addr_q    <= addr;
            sdata_q   <= store_data;
            rd_q      <= rd;
         end
         if (state == WAIT && mem_rvalid) rdata_q <= mem_rdata;
      end
   end

   // Response timeout counter, cleared on WAIT entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (state_d == WAIT && state != WAIT)
         cnt <= '0;
      else if (state == WAIT)
         cnt <= cnt + 1'b1;
   end

   // Bus, writeback and fault outputs decoded from state.
   always_comb begin
      in_ready   = (state == IDLE);
      mem_req    = (state == REQ);
      mem_we     = mem_req & ~is_load_q;
      mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
      mem_wstrb  = mem_we ? al_strb : 4'b0000;
      mem_wdata  = mem_we ? al_wdata : '0;
      wb_valid   = (state == RESP);
      wb_rd      = wb_valid ? rd_q : '0;
      wb_data    = wb_valid ? al_load : '0;
      fault      = (state == FAULT);
      fault_addr = fault ? addr_q : '0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random checks against
// a behavioural model of the load/store unit.
module tb_load_store_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready;
   logic        is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [4:0]  rd;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [31:0] fault_addr;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .rd         (rd),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .fault      (fault),
      .fault_addr (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned op_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit ref_legal(input bit ld, input bit st,
                                    input logic [2:0] f3,
                                    input logic [31:0] a);
      if (ld == st) return 0;
      if (f3[1:0] == 2'b11) return 0;
      if (st && f3[2]) return 0;
      if (f3 == 3'b110) return 0;
      return (a % op_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [2:0] f3,
                                           input logic [31:0] a);
      int unsigned m;
      m = ((1 << op_size(f3)) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                             input logic [31:0] d);
      if (op_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
      if (op_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] rdat);
      logic [63:0] v, m;
      int bits;
      bits = 8 * op_size(f3);
      m = (64'd1 << bits) - 1;
      v = {32'd0, rdat >> (8 * (a % 4))} & m;
      if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~m;
      return v[31:0];
   endfunction

   // Writeback and fault must never coincide.
   always @(negedge clk)
      if (resetn === 1'b1) chk("excl", {31'd0, wb_valid & fault}, 0);

   // One op through the unit; called at a negedge while idle.
   task automatic run_op(input bit ld, input bit st,
                         input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic [31:0] rdat,
                         input int gd, input int rdly, input bit tmo);
      chk("rdy_idle", {31'd0, in_ready}, 1);
      in_valid   = 1'b1;
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      rd         = r;
      @(negedge clk);
      in_valid = 1'b0;
      is_load  = $urandom;
      is_store = $urandom;
      addr     = $urandom;
      if (!(ld | st)) begin
         chk("ign_req", {31'd0, mem_req}, 0);
         chk("ign_rdy", {31'd0, in_ready}, 1);
         chk("ign_flt", {31'd0, fault}, 0);
         return;
      end
      if (!ref_legal(ld, st, f3, a)) begin
         chk("flt_on", {31'd0, fault}, 1);
         chk("flt_addr", fault_addr, a);
         chk("flt_noreq", {31'd0, mem_req}, 0);
         @(negedge clk);
         chk("flt_off", {31'd0, fault}, 0);
         chk("flt_rdy", {31'd0, in_ready}, 1);
         return;
      end
      for (int i = 0; i <= gd; i++) begin
         chk("req", {31'd0, mem_req}, 1);
         chk("req_rdy", {31'd0, in_ready}, 0);
         chk("maddr", mem_addr, a & 32'hFFFF_FFFC);
         chk("mwe", {31'd0, mem_we}, {31'd0, st});
         chk("wstrb", {28'd0, mem_wstrb},
             st ? {28'd0, ref_strb(f3, a)} : 32'd0);
         if (st) chk("wdata", mem_wdata, ref_wdata(f3, sd));
         if (i == gd) mem_gnt = 1'b1;
         @(negedge clk);
      end
      mem_gnt = 1'b0;
      if (st) begin
         chk("st_rdy", {31'd0, in_ready}, 1);
         chk("st_nowb", {31'd0, wb_valid}, 0);
         chk("st_noreq", {31'd0, mem_req}, 0);
         return;
      end
      if (tmo) begin
         for (int i = 0; i < TMO; i++) begin
            chk("to_wait", {31'd0, fault}, 0);
            chk("to_nowb", {31'd0, wb_valid}, 0);
            @(negedge clk);
         end
         chk("to_flt", {31'd0, fault}, 1);
         chk("to_addr", fault_addr, a);
         @(negedge clk);
         chk("to_off", {31'd0, fault}, 0);
         chk("to_rdy", {31'd0, in_ready}, 1);
         return;
      end
      for (int i = 0; i <= rdly; i++) begin
         chk("w_nowb", {31'd0, wb_valid}, 0);
         chk("w_noreq", {31'd0, mem_req}, 0);
         if (i == rdly) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdat;
         end
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("wb_v", {31'd0, wb_valid}, 1);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, r});
      chk("wb_data", wb_data, ref_load(f3, a, rdat));
      @(negedge clk);
      chk("wb_off", {31'd0, wb_valid}, 0);
      chk("ld_rdy", {31'd0, in_ready}, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [2:0] lf3 [5];
      bit ld, st, tmo;
      logic [2:0] f3;
      logic [31:0] a;
      int kind;
      lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      resetn = 1'b0;
      in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      funct3 = '0; addr = '0; store_data = '0; rd = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #3;
      chk("rst_rdy", {31'd0, in_ready}, 1);
      chk("rst_req", {31'd0, mem_req}, 0);
      chk("rst_we", {31'd0, mem_we}, 0);
      chk("rst_strb", {28'd0, mem_wstrb}, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wb", {31'd0, wb_valid}, 0);
      chk("rst_wbd", wb_data, 0);
      chk("rst_flt", {31'd0, fault}, 0);
      chk("rst_fa", fault_addr, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      run_op(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 0, 0);
      run_op(1, 0, 3'b000, 32'h202, 0, 7, 32'h12F03456, 0, 0, 0);
      run_op(1, 0, 3'b100, 32'h202, 0, 7, 32'h12F03456, 0, 0, 0);
      run_op(1, 0, 3'b010, 32'h301, 0, 3, 0, 0, 0, 0);
      run_op(1, 0, 3'b010, 32'h400, 0, 4, 0, 1, 0, 1);
      run_op(1, 0, 3'b001, 32'h502, 0, 0, 32'h8001_7FFF, 2, 3, 0);
      run_op(1, 1, 3'b010, 32'h600, 0, 1, 0, 0, 0, 0);
      run_op(0, 0, 3'b010, 32'h700, 0, 1, 0, 0, 0, 0);
      run_op(0, 1, 3'b100, 32'h800, 0, 1, 0, 0, 0, 0);
      run_op(0, 1, 3'b001, 32'h902, 32'h1234_ABCD, 0, 0, 3, 0, 0);

      // Reset while a load is requesting, then while waiting.
      chk("mr_rdy", {31'd0, in_ready}, 1);
      in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
      funct3 = 3'b010; addr = 32'hA00; rd = 5;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mr_req", {31'd0, mem_req}, 1);
      resetn = 1'b0;
      #1;
      chk("mr_req0", {31'd0, mem_req}, 0);
      chk("mr_idle", {31'd0, in_ready}, 1);
      @(negedge clk);
      resetn = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("mw_wait", {31'd0, in_ready}, 0);
      resetn = 1'b0;
      #1;
      chk("mw_req0", {31'd0, mem_req}, 0);
      chk("mw_idle", {31'd0, in_ready}, 1);
      @(negedge clk);
      resetn = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mw_nowb", {31'd0, wb_valid}, 0);
         chk("mw_noflt", {31'd0, fault}, 0);
         @(negedge clk);
      end

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 11);
         ld = (kind == 1) || (kind >= 2 && kind <= 6);
         st = (kind == 1) || (kind >= 7);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
         else if (st && !ld) f3 = lf3[$urandom_range(0, 2)];
         else f3 = lf3[$urandom_range(0, 4)];
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
         tmo = ld && !st && ($urandom_range(0, 24) == 0);
         run_op(ld, st, f3, a, $urandom, 5'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 5), tmo);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
